// File: rtl/nested_rf_feeder_pkg.sv
// Shared types and sizes for the nested register-file feeder.
package nested_rf_feeder_pkg;
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;
endpackage

// File: rtl/nested_rf_lane_steer.sv
// Places one entry in the upper or lower half of the read word; the other half is zero.
module nested_rf_lane_steer #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   entry,
  input  logic               lane,
  output logic [2*WIDTH-1:0] data_out
);
  assign data_out = lane ? {entry, {WIDTH{1'b0}}} : {{WIDTH{1'b0}}, entry};
endmodule

// File: rtl/nested_rf_feeder.sv
// Four-entry register file with a clear sweep and a one-cycle lane-steered read port.
module nested_rf_feeder #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [1:0]         wr_idx,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               clr,
  input  logic               rd_valid,
  input  logic [1:0]         rd_idx,
  input  logic               rd_lane,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_miss,
  output logic [DEPTH-1:0]   entry_valid,
  output logic               busy
);
  import nested_rf_feeder_pkg::*;

  // state | meaning
  // IDLE  | reads and writes serviced normally
  // CLEAR | cp sweeps entries 0..3, zeroing one per cycle
  state_t             state;
  logic [IDX_W-1:0]   cp;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [2*WIDTH-1:0] steered;

  assign wr_ready    = (state == IDLE) && !clr;
  assign busy        = (state == CLEAR);
  assign entry_valid = vld;

  nested_rf_lane_steer #(.WIDTH(WIDTH)) u_steer (
    .entry    (mem[rd_idx]),
    .lane     (rd_lane),
    .data_out (steered)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cp    <= '0;
      vld   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cp    <= '0;
          end else if (wr_valid) begin
            mem[wr_idx] <= wr_data;
            vld[wr_idx] <= 1'b1;
          end
        end
        CLEAR: begin
          mem[cp] <= '0;
          vld[cp] <= 1'b0;
          cp      <= cp + 2'd1;
          if (cp == IDX_W'(DEPTH - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read samples the array before this edge's write or sweep lands (no bypass).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_miss  <= 1'b0;
    end else begin
      out_valid <= rd_valid;
      out_data  <= rd_valid ? steered : '0;
      out_miss  <= rd_valid && !vld[rd_idx];
    end
  end
endmodule

// File: tb/tb_nested_rf_feeder.sv
// Randomized and directed bench for nested_rf_feeder against a behavioural register-file model.
module tb_nested_rf_feeder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [1:0] wr_idx = '0;
  logic [3:0] wr_data = '0;
  logic       clr = 1'b0;
  logic       rd_valid = 1'b0;
  logic [1:0] rd_idx = '0;
  logic       rd_lane = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_miss;
  logic [3:0] entry_valid;
  logic       busy;

  int total = 0;
  int bad = 0;

  // model: entry values, written flags, and the next entry to clear (-1 when not sweeping)
  int mdl [4];
  bit mwr [4];
  int sweep = -1;
  int exp_ov, exp_od, exp_om;

  always #5 clk = ~clk;

  nested_rf_feeder #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_idx(wr_idx), .wr_data(wr_data), .clr(clr), .rd_valid(rd_valid),
    .rd_idx(rd_idx), .rd_lane(rd_lane), .out_valid(out_valid),
    .out_data(out_data), .out_miss(out_miss), .entry_valid(entry_valid),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int model_ev();
    int v = 0;
    for (int i = 0; i < 4; i++) if (mwr[i]) v += (1 << i);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mdl[i] = 0;
      mwr[i] = 0;
    end
    sweep = -1;
    exp_ov = 0; exp_od = 0; exp_om = 0;
  endtask

  task automatic step(input bit wv, input int wi, input int wd, input bit c,
                      input bit rv, input int ri, input bit rl);
    @(negedge clk);
    wr_valid = wv; wr_idx = wi[1:0]; wr_data = wd[3:0]; clr = c;
    rd_valid = rv; rd_idx = ri[1:0]; rd_lane = rl;
    #1;
    chk("wr_ready", 16'(wr_ready), 16'((sweep < 0 && !c) ? 1 : 0));
    @(posedge clk);
    exp_ov = rv ? 1 : 0;
    exp_od = rv ? (rl ? mdl[ri] * 16 : mdl[ri]) : 0;
    exp_om = (rv && !mwr[ri]) ? 1 : 0;
    if (sweep >= 0) begin
      mdl[sweep] = 0;
      mwr[sweep] = 0;
      sweep = (sweep == 3) ? -1 : sweep + 1;
    end else if (c) begin
      sweep = 0;
    end else if (wv) begin
      mdl[wi] = wd;
      mwr[wi] = 1;
    end
    #1;
    chk("out_valid", 16'(out_valid), 16'(exp_ov));
    chk("out_data", 16'(out_data), 16'(exp_od));
    chk("out_miss", 16'(out_miss), 16'(exp_om));
    chk("entry_valid", 16'(entry_valid), 16'(model_ev()));
    chk("busy", 16'(busy), 16'(sweep >= 0 ? 1 : 0));
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_data", 16'(out_data), 16'h0);
    chk("rst_out_miss", 16'(out_miss), 16'h0);
    chk("rst_entry_valid", 16'(entry_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 0, 4'hA, 0, 0, 0, 0);
    step(1, 2, 4'h5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 1);
    chk("dir_rd2_data", 16'(out_data), 16'h50);
    chk("dir_rd2_valid", 16'(out_valid), 16'h1);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("dir_rd1_miss", 16'(out_miss), 16'h1);
    chk("dir_ev_0101", 16'(entry_valid), 16'h5);
    step(1, 0, 4'h3, 0, 1, 0, 0);
    chk("dir_nobypass", 16'(out_data), 16'h0A);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("dir_after_wr", 16'(out_data), 16'h03);

    // clear with a competing write, then confirm everything reads as a miss
    step(1, 1, 4'hF, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 1, 3, 1);
    chk("dir_clr_ev", 16'(entry_valid), 16'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, k, k[0]);
      chk("dir_clr_miss", 16'(out_miss), 16'h1);
      chk("dir_clr_data", 16'(out_data), 16'h0);
    end

    // reset in the middle of a sweep
    step(1, 1, 4'h7, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1);
    chk("mid_busy_pre", 16'(busy), 16'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_busy", 16'(busy), 16'h0);
    chk("mid_rst_ov", 16'(out_valid), 16'h0);
    chk("mid_rst_od", 16'(out_data), 16'h0);
    chk("mid_rst_om", 16'(out_miss), 16'h0);
    chk("mid_rst_ev", 16'(entry_valid), 16'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    step(1, 3, 4'h9, 0, 0, 0, 0);
    chk("post_rst_wr", 16'(entry_valid), 16'h8);

    // fill all entries then read back-to-back with alternating lanes
    for (int k = 0; k < 4; k++) step(1, k, 4'h1 + k * 3, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 0, 0, 1, k, k[0]);
      chk("b2b_valid", 16'(out_valid), 16'h1);
    end

    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
